registrador_solicitudes: RTL and testbench
==========================================

REGISTRADOR_SOLICITUDES -- requirements
Module: registrador_solicitudes

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, synchronizer depth per raw button bit (legal values 2..3).
REQ-002 SHALL have port: clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: btn_hall  input  6  raw hall buttons. Bit 0 = F1 up, 1 = F2 down, 2 = F2 up, 3 = F3 down, 4 = F3 up, 5 = F4 down. Asynchronous to clk, active-high.
REQ-005 SHALL have port: btn_cab  input  4  raw cabin buttons for F1..F4 (bit 0 = F1). Asynchronous, active-high.
REQ-006 SHALL have port: e  input  4  position code, synchronous to clk. e[1:0] = floor-1; e[2] = direction (1 up, 0 down); e[3] reserved, must be 0.
REQ-007 SHALL have port: t  input  1  service level, synchronous. 1 = cabin stopped at floor e with doors open.
REQ-008 SHALL have port: s  output  10  registered request vector. s[5:0] mirrors btn_hall mapping; s[9:6] = cabin F1..F4.
REQ-009 SHALL have port: any_req  output  1  OR of s.
REQ-010 SHALL have port: req_above  output  1  some set s bit belongs to a floor above e[1:0].
REQ-011 SHALL have port: req_below  output  1  some set s bit belongs to a floor below e[1:0].
REQ-012 SHALL have port: err  output  1  one-cycle pulse flagging an illegal service code.

Function
REQ-013 SHALL pass each of the 10 button bits through SYNC_STAGES flops, then a rising-edge detector (one further flop).
REQ-014 SHALL set s[i] on the clock edge after a detected rising edge on bit i. Raw-edge-to-s latency = SYNC_STAGES+1 cycles. A held button SHALL NOT re-set a bit after it clears.
REQ-015 SHALL define floor membership of s bits:
- F1 = {0,6}
- F2 = {1,2,7}
- F3 = {3,4,8}
- F4 = {5,9}
REQ-016 SHALL, while t=1 and e[3]=0, clear the following bits every cycle (level-based):
- e=x100 or x000 (F1): s0, s6
- e=0001: s1, s7
- e=0101: s2, s7
- e=0010: s3, s8
- e=0110: s4, s8
- e=0011 or 0111 (F4): s5, s9
REQ-017 SHALL leave the opposite-direction hall bit at F2/F3 untouched during service.
REQ-018 SHALL give clear priority over set when both hit the same bit in the same cycle. Presses to a bit being cleared SHALL be discarded, not deferred.
REQ-019 SHALL update bits not targeted by the current clear normally during t=1.
REQ-020 SHALL, when t=1 and e[3]=1, clear nothing and pulse err for exactly one cycle per cycle of that condition (registered, 1-cycle latency).
REQ-021 SHALL compute any_req, req_above and req_below combinationally from registered s and current e[1:0]. Floor e[1:0] itself counts as neither above nor below.
REQ-022 SHALL make set/clear of distinct bits in the same cycle independent; any number of bits may change per cycle.

Reset
REQ-023 SHALL, on rst_n=0 (asynchronous), force s=0, err=0, and all synchronizer and edge-detect flops to 0. any_req, req_above and req_below therefore read 0.
REQ-024 SHALL, after rst_n release, treat a button already held high as a new press once it propagates. Edge-detect state resets to 0.
REQ-025 SHALL lose any press in flight in the synchronizer when reset asserts mid-operation.

Verification
REQ-026 SHALL cover basic press: btn_cab[2] pulse 1 cycle high (after sync settle), t=0 -> s=10'h100 exactly 3 cycles later (SYNC_STAGES=2); any_req=1; with e=4'b0000: req_above=1, req_below=0.
REQ-027 SHALL cover directional service: s=10'h01E with e=4'b0101, t=1 -> next edge s=10'h01A (s2 cleared, s1/s3/s4 kept).
REQ-028 SHALL cover collision: t=1, e=4'b0110, synchronized press edge on btn_hall[4] in the same cycle -> s[4] remains 0; after t falls, the held button does not set s[4].
REQ-029 SHALL cover illegal code: t=1, e=4'b1010 for 3 cycles with s=10'h3FF -> s unchanged; err high 3 cycles, offset by 1.
REQ-030 SHALL cover reset mid-operation: s=10'h2A5 and a press in the synchronizer, rst_n low asynchronously mid-cycle -> s=0 immediately; the pending press never appears after release.
REQ-031 SHALL cover F4 either direction: s=10'h220, e=4'b0011, t=1 -> s=0, any_req=0 next cycle.

Source files
------------

// File: rtl/registrador_solicitudes.sv
// Elevator request register: synchronizes raw hall/cabin buttons, latches new presses
// into s, and clears the bits served by the cabin at its current floor and direction.
module registrador_solicitudes #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn_hall,
  input  logic [3:0] btn_cab,
  input  logic [3:0] e,
  input  logic       t,
  output logic [9:0] s,
  output logic       any_req,
  output logic       req_above,
  output logic       req_below,
  output logic       err
);

  localparam int NB = 10;

  // Floor index (0 = F1) owning each bit of s.
  function automatic logic [1:0] bit_floor(input int b);
    case (b)
      0, 6:    bit_floor = 2'd0;
      1, 2, 7: bit_floor = 2'd1;
      3, 4, 8: bit_floor = 2'd2;
      default: bit_floor = 2'd3;
    endcase
  endfunction

  logic [NB-1:0]                  raw;
  logic [SYNC_STAGES-1:0][NB-1:0] sync_reg;
  logic [NB-1:0]                  prev_reg;
  logic [NB-1:0]                  rise;
  logic [NB-1:0]                  clr_mask;
  logic [NB-1:0]                  s_reg;
  logic [NB-1:0]                  s_next;
  logic                           err_reg;
  logic                           err_next;
  logic [NB-1:0]                  above_bits;
  logic [NB-1:0]                  below_bits;

  assign raw = {btn_cab, btn_hall};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

  // Hall bits at F2/F3 are cleared only for the direction the cabin is travelling.
  always_comb begin
    clr_mask = '0;
    if (t && !e[3]) begin
      case (e[1:0])
        2'd0: begin
          clr_mask[0] = 1'b1;
          clr_mask[6] = 1'b1;
        end
        2'd1: begin
          clr_mask[7] = 1'b1;
          if (e[2]) clr_mask[2] = 1'b1;
          else      clr_mask[1] = 1'b1;
        end
        2'd2: begin
          clr_mask[8] = 1'b1;
          if (e[2]) clr_mask[4] = 1'b1;
          else      clr_mask[3] = 1'b1;
        end
        default: begin
          clr_mask[5] = 1'b1;
          clr_mask[9] = 1'b1;
        end
      endcase
    end
  end

  // Clear wins over a simultaneous press; that press is dropped, not deferred.
  assign s_next   = (s_reg | rise) & ~clr_mask;
  assign err_next = t & e[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg   <= '0;
      err_reg <= 1'b0;
    end else begin
      s_reg   <= s_next;
      err_reg <= err_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_dir
      localparam logic [1:0] FL = bit_floor(gi);
      assign above_bits[gi] = s_reg[gi] && (FL > e[1:0]);
      assign below_bits[gi] = s_reg[gi] && (FL < e[1:0]);
    end
  endgenerate

  assign s         = s_reg;
  assign err       = err_reg;
  assign any_req   = |s_reg;
  assign req_above = |above_bits;
  assign req_below = |below_bits;

endmodule

// File: tb/tb_registrador_solicitudes.sv
// Bench for registrador_solicitudes: directed scenarios plus randomized traffic
// checked against a rule-based request model.
module tb_registrador_solicitudes;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] btn_hall = '0;
  logic [3:0] btn_cab = '0;
  logic [3:0] e = '0;
  logic       t = 1'b0;
  logic [9:0] s;
  logic       any_req, req_above, req_below, err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [9:0] s_m = '0;
  logic       err_m = 1'b0;
  logic [9:0] hist [0:SS];

  registrador_solicitudes #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .btn_hall(btn_hall), .btn_cab(btn_cab),
    .e(e), .t(t), .s(s), .any_req(any_req), .req_above(req_above),
    .req_below(req_below), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int floor_of(input int b);
    if (b == 0 || b == 6) return 0;
    if (b == 1 || b == 2 || b == 7) return 1;
    if (b == 3 || b == 4 || b == 8) return 2;
    return 3;
  endfunction

  function automatic bit is_up(input int b);
    return (b == 0 || b == 2 || b == 4);
  endfunction

  function automatic bit served(input int b, input logic tt, input logic [3:0] ee);
    int fl;
    fl = int'(ee[1:0]);
    if (!tt || ee[3]) return 0;
    if (floor_of(b) != fl) return 0;
    if (b >= 6 || fl == 0 || fl == 3) return 1;
    return (is_up(b) == ee[2]);
  endfunction

  function automatic bit m_above(input logic [9:0] v, input logic [1:0] fl);
    for (int b = 0; b < 10; b++) if (v[b] && floor_of(b) > int'(fl)) return 1;
    return 0;
  endfunction

  function automatic bit m_below(input logic [9:0] v, input logic [1:0] fl);
    for (int b = 0; b < 10; b++) if (v[b] && floor_of(b) < int'(fl)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    s_m   = '0;
    err_m = 1'b0;
    for (int k = 0; k <= SS; k++) hist[k] = '0;
  endtask

  // A press takes effect when the raw sample SS edges old is high and the one before it low.
  task automatic model_step();
    logic [9:0] set_v;
    set_v = hist[SS-1] & ~hist[SS];
    for (int b = 0; b < 10; b++) begin
      if (served(b, t, e)) s_m[b] = 1'b0;
      else if (set_v[b])   s_m[b] = 1'b1;
    end
    err_m = t & e[3];
    for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {btn_cab, btn_hall};
  endtask

  task automatic run_cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic apply_reset();
    btn_hall = '0; btn_cab = '0; t = 1'b0; e = '0;
    rst_n = 1'b0;
    model_reset();
    run_cycle();
    run_cycle();
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [9:0] mask);
    t = 1'b0;
    {btn_cab, btn_hall} = mask;
    run_cycle();
    btn_hall = '0; btn_cab = '0;
    for (int k = 0; k < SS + 2; k++) run_cycle();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (s !== 10'h000) begin n_fail++; $display("FAIL reset_s: got %h expected 000", s); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_tests++; if ({any_req, req_above, req_below} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {any_req, req_above, req_below}); end
    run_cycle();
    run_cycle();
    n_tests++; if (s !== 10'h000) begin n_fail++; $display("FAIL reset_hold_s: got %h expected 000", s); end
    rst_n = 1'b1;
    $display("[TB] reset: s=%h err=%b", s, err);
  endtask

  task automatic test_basic_press();
    apply_reset();
    for (int k = 0; k < 3; k++) run_cycle();
    e = 4'b0000; t = 1'b0;
    btn_cab = 4'b0100;
    run_cycle();
    btn_cab = 4'b0000;
    n_tests++; if (s !== 10'h000) begin n_fail++; $display("FAIL basic_lat1: got %h expected 000", s); end
    run_cycle();
    n_tests++; if (s !== 10'h000) begin n_fail++; $display("FAIL basic_lat2: got %h expected 000", s); end
    run_cycle();
    n_tests++; if (s !== 10'h100) begin n_fail++; $display("FAIL basic_s: got %h expected 100", s); end
    n_tests++; if ({any_req, req_above, req_below} !== 3'b110) begin
      n_fail++; $display("FAIL basic_flags: got %b expected 110", {any_req, req_above, req_below}); end
    n_tests++; if (s !== s_m) begin n_fail++; $display("FAIL basic_model: got %h expected %h", s, s_m); end
    $display("[TB] basic press: s=%h any=%b above=%b below=%b", s, any_req, req_above, req_below);
  endtask

  task automatic test_directional();
    apply_reset();
    load(10'h01E);
    n_tests++; if (s !== 10'h01E) begin n_fail++; $display("FAIL dir_load: got %h expected 01E", s); end
    e = 4'b0101; t = 1'b1;
    run_cycle();
    t = 1'b0;
    n_tests++; if (s !== 10'h01A) begin n_fail++; $display("FAIL dir_clear: got %h expected 01A", s); end
    n_tests++; if ({req_above, req_below} !== 2'b10) begin
      n_fail++; $display("FAIL dir_flags: got %b expected 10", {req_above, req_below}); end
    $display("[TB] directional service: s=%h", s);
  endtask

  task automatic test_collision();
    apply_reset();
    e = 4'b0110; t = 1'b1;
    btn_hall = 6'b010000;
    btn_cab  = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      n_tests++; if (s[4] !== 1'b0) begin n_fail++; $display("FAIL coll_during: cycle %0d got s4=%b expected 0", k, s[4]); end
    end
    n_tests++; if (s !== 10'h040) begin n_fail++; $display("FAIL coll_other: got %h expected 040", s); end
    t = 1'b0;
    for (int k = 0; k < 5; k++) run_cycle();
    n_tests++; if (s[4] !== 1'b0) begin n_fail++; $display("FAIL coll_after: got s4=%b expected 0", s[4]); end
    btn_hall = '0; btn_cab = '0;
    $display("[TB] collision: s=%h", s);
  endtask

  task automatic test_illegal();
    apply_reset();
    load(10'h3FF);
    e = 4'b1010; t = 1'b1;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_pre: got %b expected 0", err); end
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err: cycle %0d got %b expected 1", k, err); end
      n_tests++; if (s !== 10'h3FF) begin n_fail++; $display("FAIL ill_s: cycle %0d got %h expected 3FF", k, s); end
    end
    t = 1'b0; e = 4'b0000;
    run_cycle();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_post: got %b expected 0", err); end
    $display("[TB] illegal code: s=%h err=%b", s, err);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load(10'h2A5);
    n_tests++; if (s !== 10'h2A5) begin n_fail++; $display("FAIL mid_load: got %h expected 2A5", s); end
    btn_hall = 6'b000010;
    run_cycle();
    btn_hall = '0;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (s !== 10'h000) begin n_fail++; $display("FAIL mid_async: got %h expected 000", s); end
    run_cycle();
    run_cycle();
    #3 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      run_cycle();
      n_tests++; if (s !== 10'h000) begin n_fail++; $display("FAIL mid_lost: cycle %0d got %h expected 000", k, s); end
    end
    $display("[TB] reset mid-operation: s=%h", s);
  endtask

  task automatic test_held_through_reset();
    btn_cab = 4'b0001;
    rst_n = 1'b0;
    model_reset();
    run_cycle();
    run_cycle();
    rst_n = 1'b1;
    run_cycle();
    run_cycle();
    n_tests++; if (s !== 10'h000) begin n_fail++; $display("FAIL held_early: got %h expected 000", s); end
    run_cycle();
    n_tests++; if (s !== 10'h040) begin n_fail++; $display("FAIL held_press: got %h expected 040", s); end
    btn_cab = '0;
    $display("[TB] held through reset: s=%h", s);
  endtask

  task automatic test_f4();
    apply_reset();
    load(10'h220);
    e = 4'b0011; t = 1'b1;
    run_cycle();
    t = 1'b0;
    n_tests++; if (s !== 10'h000) begin n_fail++; $display("FAIL f4_s: got %h expected 000", s); end
    n_tests++; if (any_req !== 1'b0) begin n_fail++; $display("FAIL f4_any: got %b expected 0", any_req); end
    $display("[TB] F4 service: s=%h any=%b", s, any_req);
  endtask

  task automatic test_random();
    int bad;
    apply_reset();
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      btn_hall = 6'($urandom & $urandom & $urandom);
      btn_cab  = 4'($urandom & $urandom & $urandom);
      e = {($urandom_range(0, 7) == 0), 3'($urandom)};
      t = ($urandom_range(0, 2) == 0);
      run_cycle();
      n_tests++; if (s !== s_m) begin n_fail++; bad++; $display("FAIL rnd_s: cycle %0d got %h expected %h", k, s, s_m); end
      n_tests++; if (err !== err_m) begin n_fail++; bad++; $display("FAIL rnd_err: cycle %0d got %b expected %b", k, err, err_m); end
      n_tests++; if ({any_req, req_above, req_below} !== {(|s_m), m_above(s_m, e[1:0]), m_below(s_m, e[1:0])}) begin
        n_fail++; bad++;
        $display("FAIL rnd_flags: cycle %0d got %b expected %b", k, {any_req, req_above, req_below},
                 {(|s_m), m_above(s_m, e[1:0]), m_below(s_m, e[1:0])});
      end
    end
    btn_hall = '0; btn_cab = '0; t = 1'b0;
    $display("[TB] random traffic: 400 cycles, %0d discrepancies", bad);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_press();
    test_directional();
    test_collision();
    test_illegal();
    test_reset_mid();
    test_held_through_reset();
    test_f4();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
